option_line_fifo: RTL and testbench

OPTION_LINE_FIFO -- requirements
Module: option_line_fifo

---
 rtl/option_line_fifo_if.sv | 38 +++
 rtl/option_line_fifo.sv | 218 +++++++++++++++++++++
 tb/tb_option_line_fifo.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/option_line_fifo_if.sv
// option_line_fifo_if: bundles the option stream, solver write-back, pop
// output and status/statistics signals of option_line_fifo.
// master = producer/solver side, slave = the FIFO itself.
interface option_line_fifo_if #(
  parameter int N      = 3,
  parameter int DEPTH  = 8,
  parameter int LINE_W = 1024
) ();
  logic                     opt_valid;
  logic [N-1:0]             opt_data;
  logic                     opt_last;
  logic [7:0]               line_id;
  logic                     opt_ready;
  logic                     wb_valid;
  logic [LINE_W-1:0]        wb_data;
  logic                     solver_ready;
  logic                     valid_out;
  logic [LINE_W-1:0]        data_out;
  logic [6:0]               options_per_line;
  logic                     empty;
  logic                     full;
  logic [1:0]               err;
  logic [15:0]              stat_in;
  logic [15:0]              stat_out;
  logic [$clog2(DEPTH):0]   stat_hwm;

  modport master (
    output opt_valid, opt_data, opt_last, line_id, wb_valid, wb_data, solver_ready,
    input  opt_ready, valid_out, data_out, options_per_line, empty, full, err,
           stat_in, stat_out, stat_hwm
  );

  modport slave (
    input  opt_valid, opt_data, opt_last, line_id, wb_valid, wb_data, solver_ready,
    output opt_ready, valid_out, data_out, options_per_line, empty, full, err,
           stat_in, stat_out, stat_hwm
  );
endinterface

// File: rtl/option_line_fifo.sv
// option_line_fifo: packs a stream of N-bit fill options for one board line
// into a single LINE_W entry and queues entries (plus solver write-backs) in a
// DEPTH-deep FIFO feeding the solver one entry at a time.
// Entry layout: [6:0] option count, [7] column flag, [15:8] line_id,
// option k at bits 16+k*N, all other bits zero.
// Optional feature: define FIFO_STATS_EN to enable push/pop counters and the
// occupancy high-water mark; otherwise those outputs are tied to zero.
module option_line_fifo #(
  parameter int N      = 3,
  parameter int DEPTH  = 8,
  parameter int LINE_W = 1024
) (
  input logic              clk,
  input logic              rst,
  option_line_fifo_if.slave bus
);

  localparam int AW       = $clog2(DEPTH);
  localparam int OPT_BASE = 16;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  // packer state
  logic [1:0]        state_q;
  logic [6:0]        cnt_q;
  logic              drop_q;
  logic [7:0]        id_q;
  logic [LINE_W-1:0] buf_q;

  // packer combinational helpers
  logic              beat;
  logic [6:0]        cur_cnt;
  logic              base_drop;
  logic              drop_nxt;
  logic              ovf;
  int                need_bits;
  logic [31:0]       opt_sh;
  logic [LINE_W-1:0] opt_ext;
  logic [LINE_W-1:0] opt_word;
  logic [LINE_W-1:0] entry;

  // FIFO storage and control
  logic [LINE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic [AW:0]       count_nxt;
  logic [1:0]        err_q;
  logic              is_empty;
  logic              is_full;
  logic              pop;
  logic              slot_free;
  logic              wb_push;
  logic              commit_push;
  logic              push;
  logic [LINE_W-1:0] push_data;

  // pop output stage
  logic              vld_p1;
  logic [LINE_W-1:0] data_p1;
  logic [6:0]        opl_p1;

  assign beat      = bus.opt_valid && (state_q != S_COMMIT);
  assign cur_cnt   = (state_q == S_IDLE) ? 7'd0 : cnt_q;
  assign base_drop = (state_q == S_IDLE) ? 1'b0 : drop_q;
  assign drop_nxt  = base_drop | ovf;

  // Overflow check for the incoming beat and placement of its option bits
  always_comb begin
    need_bits = OPT_BASE + (int'(cur_cnt) + 1) * N;
    ovf       = (cur_cnt == 7'd127) || (need_bits > LINE_W);
    opt_sh    = 32'(OPT_BASE) + 32'(cur_cnt) * 32'(N);
    opt_ext   = '0;
    opt_ext[N-1:0] = bus.opt_data;
    opt_word  = opt_ext << opt_sh;
  end

  assign entry = {buf_q[LINE_W-1:OPT_BASE], id_q, id_q[7], cnt_q};

  assign is_empty    = (count_q == '0);
  assign is_full     = (count_q == (AW+1)'(DEPTH));
  assign pop         = bus.solver_ready && !is_empty && !vld_p1;
  assign slot_free   = !is_full || pop;
  assign wb_push     = bus.wb_valid && slot_free;
  assign commit_push = (state_q == S_COMMIT) && !wb_push && slot_free;
  assign push        = wb_push || commit_push;
  assign push_data   = wb_push ? bus.wb_data : entry;

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_nxt = count_q;
    if (push && !pop)
      count_nxt = count_q + 1'b1;
    else if (!push && pop)
      count_nxt = count_q - 1'b1;
  end

  // Packer FSM: IDLE -> ACCUM -> COMMIT -> IDLE, dropping overlong lines
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (beat) begin
            cnt_q  <= drop_nxt ? cur_cnt : cur_cnt + 7'd1;
            drop_q <= drop_nxt;
            if (bus.opt_last)
              state_q <= drop_nxt ? S_IDLE : S_COMMIT;
            else
              state_q <= S_ACCUM;
          end
        end
        S_COMMIT: begin
          if (commit_push)
            state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Line assembly buffer: first beat restarts it, later beats OR in options
  always_ff @(posedge clk) begin
    if (beat) begin
      if (state_q == S_IDLE) begin
        id_q  <= bus.line_id;
        buf_q <= opt_word;
      end else if (!drop_nxt) begin
        buf_q <= buf_q | opt_word;
      end
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_q] <= push_data;
  end

  // Pointers, occupancy and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 2'b00;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_nxt;
      if (beat && ovf)
        err_q[0] <= 1'b1;
      if (bus.wb_valid && !slot_free)
        err_q[1] <= 1'b1;
    end
  end

  // ---- stage p1: registered pop output, data held until next pop ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      opl_p1  <= '0;
    end else begin
      vld_p1 <= pop;
      if (pop) begin
        data_p1 <= mem[rd_ptr_q];
        opl_p1  <= mem[rd_ptr_q][6:0];
      end
    end
  end

  assign bus.opt_ready        = (state_q != S_COMMIT);
  assign bus.valid_out        = vld_p1;
  assign bus.data_out         = data_p1;
  assign bus.options_per_line = opl_p1;
  assign bus.empty            = is_empty;
  assign bus.full             = is_full;
  assign bus.err              = err_q;

`ifdef FIFO_STATS_EN
  logic [15:0] stat_in_q;
  logic [15:0] stat_out_q;
  logic [AW:0] hwm_q;

  // Saturating push/pop counters and peak occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_in_q  <= '0;
      stat_out_q <= '0;
      hwm_q      <= '0;
    end else begin
      if (push && (stat_in_q != 16'hFFFF))
        stat_in_q <= stat_in_q + 16'd1;
      if (pop && (stat_out_q != 16'hFFFF))
        stat_out_q <= stat_out_q + 16'd1;
      if (count_nxt > hwm_q)
        hwm_q <= count_nxt;
    end
  end

  assign bus.stat_in  = stat_in_q;
  assign bus.stat_out = stat_out_q;
  assign bus.stat_hwm = hwm_q;
`else
  assign bus.stat_in  = '0;
  assign bus.stat_out = '0;
  assign bus.stat_hwm = '0;
`endif

endmodule

// File: tb/tb_option_line_fifo.sv
// tb_option_line_fifo: directed bench for option_line_fifo with
// hand-computed expected entries.
module tb_option_line_fifo;

  localparam int N      = 3;
  localparam int DEPTH  = 8;
  localparam int LINE_W = 1024;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  option_line_fifo_if #(.N(N), .DEPTH(DEPTH), .LINE_W(LINE_W)) bus ();

  option_line_fifo #(.N(N), .DEPTH(DEPTH), .LINE_W(LINE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] popped[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.opt_valid    = 1'b0;
    bus.opt_data     = '0;
    bus.opt_last     = 1'b0;
    bus.line_id      = '0;
    bus.wb_valid     = 1'b0;
    bus.wb_data      = '0;
    bus.solver_ready = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic send_beat(input logic [N-1:0] d, input logic last, input logic [7:0] id);
    int guard = 0;
    bus.opt_valid = 1'b1;
    bus.opt_data  = d;
    bus.opt_last  = last;
    bus.line_id   = id;
    while (!bus.opt_ready && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) check_eq("opt_ready_timeout", 64'(bus.opt_ready), 64'd1);
    tick();
    if (last) bus.opt_valid = 1'b0;
  endtask

  task automatic wait_vld(input string tag);
    int guard = 0;
    while (!bus.valid_out && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check_eq(tag, 64'(bus.valid_out), 64'd1);
  endtask

  task automatic drain(input int cycles);
    popped.delete();
    bus.solver_ready = 1'b1;
    repeat (cycles) begin
      tick();
      if (bus.valid_out) popped.push_back(bus.data_out[15:8]);
    end
    bus.solver_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int np;
    int guard;

    // ---------- reset values and basic 3-option line ----------
    do_reset();
    check_eq("rst_valid_out", 64'(bus.valid_out), 64'd0);
    check_eq("rst_empty", 64'(bus.empty), 64'd1);
    check_eq("rst_full", 64'(bus.full), 64'd0);
    check_eq("rst_opt_ready", 64'(bus.opt_ready), 64'd1);
    check_eq("rst_err", 64'(bus.err), 64'd0);
    check_eq("rst_data_out", bus.data_out[63:0], 64'd0);
    check_eq("rst_opl", 64'(bus.options_per_line), 64'd0);
    check_eq("rst_stat_in", 64'(bus.stat_in), 64'd0);
    check_eq("rst_stat_out", 64'(bus.stat_out), 64'd0);
    check_eq("rst_stat_hwm", 64'(bus.stat_hwm), 64'd0);

    bus.solver_ready = 1'b1;
    send_beat(3'b100, 1'b0, 8'h02);
    send_beat(3'b010, 1'b0, 8'h02);
    send_beat(3'b001, 1'b1, 8'h02);
    check_eq("basic_commit_ready", 64'(bus.opt_ready), 64'd0);
    tick();
    check_eq("basic_vld_early", 64'(bus.valid_out), 64'd0);
    check_eq("basic_not_empty", 64'(bus.empty), 64'd0);
    tick();
    check_eq("basic_vld", 64'(bus.valid_out), 64'd1);
    check_eq("basic_data", bus.data_out[63:0], 64'h0000_0000_0054_0203);
    check_eq("basic_opl", 64'(bus.options_per_line), 64'd3);
    tick();
    check_eq("basic_vld_pulse", 64'(bus.valid_out), 64'd0);
    check_eq("basic_data_hold", bus.data_out[63:0], 64'h0000_0000_0054_0203);

    // ---------- fill to full, ninth line stalls in COMMIT ----------
    do_reset();
    for (int i = 0; i < DEPTH; i++) send_beat(3'(i), 1'b1, 8'h10 + 8'(i));
    tick();
    check_eq("fill_full", 64'(bus.full), 64'd1);
    send_beat(3'd7, 1'b1, 8'h20);
    tick();
    check_eq("stall_ready", 64'(bus.opt_ready), 64'd0);
    check_eq("stall_full", 64'(bus.full), 64'd1);
    tick();
    check_eq("stall_ready2", 64'(bus.opt_ready), 64'd0);
    bus.solver_ready = 1'b1;
    tick();
    bus.solver_ready = 1'b0;
    check_eq("pop_vld", 64'(bus.valid_out), 64'd1);
    check_eq("pop_data", bus.data_out[63:0], 64'h0000_0000_0000_1001);
    check_eq("pop_full_kept", 64'(bus.full), 64'd1);
    check_eq("pop_commit_done", 64'(bus.opt_ready), 64'd1);
    drain(30);
    check_eq("fill_drain_n", 64'(popped.size()), 64'd8);
    if (popped.size() == 8) begin
      check_eq("fill_first", 64'(popped[0]), 64'h11);
      check_eq("fill_last", 64'(popped[7]), 64'h20);
    end
    check_eq("fill_empty", 64'(bus.empty), 64'd1);

    // ---------- write-back beats a pending commit for the last slot ----------
    do_reset();
    for (int i = 0; i < DEPTH - 1; i++) send_beat(3'(i), 1'b1, 8'h30 + 8'(i));
    tick();
    send_beat(3'd5, 1'b1, 8'h40);
    bus.wb_valid = 1'b1;
    bus.wb_data  = '0;
    bus.wb_data[31:0] = 32'h00AB_EE05;
    tick();
    bus.wb_valid = 1'b0;
    check_eq("wb_full", 64'(bus.full), 64'd1);
    check_eq("wb_packer_wait", 64'(bus.opt_ready), 64'd0);
    check_eq("wb_no_err", 64'(bus.err), 64'd0);
    drain(30);
    check_eq("wb_drain_n", 64'(popped.size()), 64'd9);
    if (popped.size() == 9) begin
      check_eq("wb_order_prev", 64'(popped[6]), 64'h36);
      check_eq("wb_order_wb", 64'(popped[7]), 64'hEE);
      check_eq("wb_order_line", 64'(popped[8]), 64'h40);
    end

    // ---------- write-back dropped while full ----------
    do_reset();
    for (int i = 0; i < DEPTH; i++) send_beat(3'(i), 1'b1, 8'h50 + 8'(i));
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_data  = '0;
    bus.wb_data[15:0] = 16'hCC00;
    tick();
    bus.wb_valid = 1'b0;
    check_eq("drop_err", 64'(bus.err), 64'b10);
    check_eq("drop_full", 64'(bus.full), 64'd1);
    drain(30);
    check_eq("drop_drain_n", 64'(popped.size()), 64'd8);
    if (popped.size() == 8) check_eq("drop_last", 64'(popped[7]), 64'h57);

    // ---------- 128-option line overflows and is discarded ----------
    do_reset();
    for (int k = 0; k < 128; k++) send_beat(3'(k), (k == 127), 8'h60);
    check_eq("ovf_err", 64'(bus.err), 64'b01);
    tick();
    tick();
    check_eq("ovf_empty", 64'(bus.empty), 64'd1);
    check_eq("ovf_idle", 64'(bus.opt_ready), 64'd1);
    bus.solver_ready = 1'b1;
    send_beat(3'b110, 1'b1, 8'h61);
    wait_vld("ovf_next_timeout");
    check_eq("ovf_next_data", bus.data_out[63:0], 64'h0000_0000_0006_6101);
    check_eq("ovf_err_sticky", 64'(bus.err), 64'b01);

    // ---------- reset in the middle of a line ----------
    tick();
    send_beat(3'b111, 1'b0, 8'h81);
    send_beat(3'b011, 1'b0, 8'h81);
    bus.opt_valid = 1'b0;
    rst = 1'b0;
    #2;
    check_eq("mid_rst_vld", 64'(bus.valid_out), 64'd0);
    check_eq("mid_rst_empty", 64'(bus.empty), 64'd1);
    check_eq("mid_rst_full", 64'(bus.full), 64'd0);
    check_eq("mid_rst_ready", 64'(bus.opt_ready), 64'd1);
    check_eq("mid_rst_err", 64'(bus.err), 64'd0);
    check_eq("mid_rst_data", bus.data_out[63:0], 64'd0);
    check_eq("mid_rst_opl", 64'(bus.options_per_line), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    bus.solver_ready = 1'b1;
    send_beat(3'b101, 1'b1, 8'h82);
    wait_vld("mid_rst_timeout");
    check_eq("mid_rst_opl1", 64'(bus.options_per_line), 64'd1);
    check_eq("mid_rst_new_data", bus.data_out[63:0], 64'h0000_0000_0005_8281);

    // ---------- statistics: 5 pushes then 3 pops ----------
    do_reset();
    for (int i = 0; i < 5; i++) send_beat(3'(i), 1'b1, 8'h70 + 8'(i));
    tick();
    np = 0;
    guard = 0;
    bus.solver_ready = 1'b1;
    while (np < 3 && guard < 40) begin
      tick();
      guard++;
      if (bus.valid_out) np++;
      if (np == 3) bus.solver_ready = 1'b0;
    end
    bus.solver_ready = 1'b0;
    check_eq("stat_pops", 64'(np), 64'd3);
    tick();
    tick();
`ifdef FIFO_STATS_EN
    check_eq("stat_in", 64'(bus.stat_in), 64'd5);
    check_eq("stat_out", 64'(bus.stat_out), 64'd3);
    check_eq("stat_hwm", 64'(bus.stat_hwm), 64'd5);
`else
    check_eq("stat_in_off", 64'(bus.stat_in), 64'd0);
    check_eq("stat_out_off", 64'(bus.stat_out), 64'd0);
    check_eq("stat_hwm_off", 64'(bus.stat_hwm), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
